// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the raster timing generator.
// Holds the 1024x768@60 (65 MHz) and 640x480@60 (25.175 MHz) porch/sync
// figures, the 11-bit coordinate type and the sync polarity encodings.
package vga_timing_pkg;

   typedef logic [10:0] coord_t;

   // Largest total that an 11-bit coordinate can count through.
   localparam int COORD_LIMIT = 2048;

   localparam bit SYNC_ACTIVE_LOW  = 1'b0;
   localparam bit SYNC_ACTIVE_HIGH = 1'b1;

   // 1024x768@60
   localparam int XGA_H_VISIBLE = 1024;
   localparam int XGA_H_FP      = 24;
   localparam int XGA_H_SYNC    = 136;
   localparam int XGA_H_BP      = 160;
   localparam int XGA_V_VISIBLE = 768;
   localparam int XGA_V_FP      = 3;
   localparam int XGA_V_SYNC    = 6;
   localparam int XGA_V_BP      = 29;

   // 640x480@60
   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FP      = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BP      = 48;
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FP      = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BP      = 33;

   // Half-open window test: lo <= v < hi.
   function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MODULUS up-counter with enable.
//   clk, rst  : clock, synchronous active-high reset (loads MODULUS-1)
//   en        : advance by one on this edge
//   cnt       : registered count
//   cnt_nxt   : value cnt takes at the next edge (lets the parent register
//               decodes that line up with cnt)
//   wrap      : en is high and cnt is at MODULUS-1, i.e. cnt goes to 0 next
module wrap_counter
   import vga_timing_pkg::*;
#(
   parameter int MODULUS = 1344
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   output coord_t cnt,
   output coord_t cnt_nxt,
   output logic   wrap
);

   localparam coord_t LAST = coord_t'(MODULUS - 1);

   coord_t cnt_q;

   always_comb begin
      wrap    = en && (cnt_q == LAST);
      cnt_nxt = cnt_q;
      if (en) begin
         cnt_nxt = (cnt_q == LAST) ? '0 : cnt_q + 11'd1;
      end
   end

   // Reset parks on the last count so the first enable lands on 0 and
   // produces the wrap that starts the first line/frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= LAST;
      end else begin
         cnt_q <= cnt_nxt;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line coordinates plus sync, visible and
// start-of-line/frame pulses. Counting is gated by pix_en so the block runs
// from a native pixel clock (pix_en tied high) or a faster clock + strobe.
// hc = vc = 0 is the first visible pixel of the first visible line.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   pix_en       pixel strobe; counters advance only when high
//   hc, vc       pixel / line coordinates (11 bits)
//   hsync, vsync sync outputs, active level SYNC_POL
//   visible      hc < H_VISIBLE and vc < V_VISIBLE
//   line_start   one-clk pulse on the edge where hc becomes 0
//   frame_start  one-clk pulse on the edge where (hc,vc) becomes (0,0)
//
// Build option VGA_TIMING_DELAY_EN: hsync, vsync and visible pass through one
// more pixel-enabled register so they lag hc/vc by one pixel, matching colour
// from mappers that register cell indices taken from hc/vc. The pulses are
// never delayed.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = XGA_H_VISIBLE,
   parameter int H_FP      = XGA_H_FP,
   parameter int H_SYNC    = XGA_H_SYNC,
   parameter int H_BP      = XGA_H_BP,
   parameter int V_VISIBLE = XGA_V_VISIBLE,
   parameter int V_FP      = XGA_V_FP,
   parameter int V_SYNC    = XGA_V_SYNC,
   parameter int V_BP      = XGA_V_BP,
   parameter bit SYNC_POL  = SYNC_ACTIVE_LOW
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   pix_en,
   output coord_t hc,
   output coord_t vc,
   output logic   hsync,
   output logic   vsync,
   output logic   visible,
   output logic   line_start,
   output logic   frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam coord_t H_VIS_END = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS_END = coord_t'(V_VISIBLE);
   localparam coord_t HS_START  = coord_t'(H_VISIBLE + H_FP);
   localparam coord_t HS_END    = coord_t'(H_VISIBLE + H_FP + H_SYNC);
   localparam coord_t VS_START  = coord_t'(V_VISIBLE + V_FP);
   localparam coord_t VS_END    = coord_t'(V_VISIBLE + V_FP + V_SYNC);

   if (H_TOTAL > COORD_LIMIT) begin : g_h_total_chk
      $error("vga_timing_gen: horizontal total exceeds 2048");
   end
   if (V_TOTAL > COORD_LIMIT) begin : g_v_total_chk
      $error("vga_timing_gen: vertical total exceeds 2048");
   end

   coord_t hc_q;
   coord_t vc_q;
   coord_t hc_nxt;
   coord_t vc_nxt;
   logic   h_wrap;
   logic   v_wrap;
   logic   v_en;

   assign v_en = pix_en & h_wrap;

   wrap_counter #(.MODULUS(H_TOTAL)) u_hcnt (
      .clk     (clk),
      .rst     (rst),
      .en      (pix_en),
      .cnt     (hc_q),
      .cnt_nxt (hc_nxt),
      .wrap    (h_wrap)
   );

   wrap_counter #(.MODULUS(V_TOTAL)) u_vcnt (
      .clk     (clk),
      .rst     (rst),
      .en      (v_en),
      .cnt     (vc_q),
      .cnt_nxt (vc_nxt),
      .wrap    (v_wrap)
   );

   // Decoding the next counter values means the registered levels change on
   // the same edge as hc/vc. vc only moves when hc wraps, so vsync changes
   // at hc = 0 and always covers whole lines.
   logic hsync_nxt;
   logic vsync_nxt;
   logic visible_nxt;

   always_comb begin
      hsync_nxt   = in_window(hc_nxt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync_nxt   = in_window(vc_nxt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      visible_nxt = (hc_nxt < H_VIS_END) && (vc_nxt < V_VIS_END);
   end

   logic hsync_q;
   logic vsync_q;
   logic visible_q;
   logic line_start_q;
   logic frame_start_q;

   // v_wrap already requires a horizontal wrap, so frame_start implies
   // line_start. Both wraps include pix_en, so a stall yields one pulse only.
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         visible_q     <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hsync_q       <= hsync_nxt;
         vsync_q       <= vsync_nxt;
         visible_q     <= visible_nxt;
         line_start_q  <= h_wrap;
         frame_start_q <= v_wrap;
      end
   end

`ifdef VGA_TIMING_DELAY_EN
   logic hsync_d;
   logic vsync_d;
   logic visible_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_d   <= ~SYNC_POL;
         vsync_d   <= ~SYNC_POL;
         visible_d <= 1'b0;
      end else if (pix_en) begin
         hsync_d   <= hsync_q;
         vsync_d   <= vsync_q;
         visible_d <= visible_q;
      end
   end

   assign hsync   = hsync_d;
   assign vsync   = vsync_d;
   assign visible = visible_d;
`else
   assign hsync   = hsync_q;
   assign vsync   = vsync_q;
   assign visible = visible_q;
`endif

   assign hc          = hc_q;
   assign vc          = vc_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 1024x768 instance plus a tiny
// active-high-sync instance (so whole frames fit in a short run), both fed
// the same rst/pix_en. Expected values come from a frame-position model:
// each instance is a single pixel index into its frame, and every output is
// derived from that index with division/modulo and the porch windows.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_DELAY_EN
   localparam bit DLY = 1'b1;
`else
   localparam bit DLY = 1'b0;
`endif

   localparam int HV [2] = '{1024, 20};
   localparam int HF [2] = '{24, 3};
   localparam int HS [2] = '{136, 5};
   localparam int HB [2] = '{160, 4};
   localparam int VV [2] = '{768, 12};
   localparam int VF [2] = '{3, 2};
   localparam int VS [2] = '{6, 3};
   localparam int VB [2] = '{29, 3};
   localparam bit POL [2] = '{1'b0, 1'b1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        pix_en;
   logic [10:0] hc0, vc0, hc1, vc1;
   logic        hs0, vs0, vis0, ls0, fs0;
   logic        hs1, vs1, vis1, ls1, fs1;

   vga_timing_gen dut (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .hc(hc0), .vc(vc0), .hsync(hs0), .vsync(vs0), .visible(vis0),
      .line_start(ls0), .frame_start(fs0)
   );

   vga_timing_gen #(
      .H_VISIBLE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
      .V_VISIBLE(12), .V_FP(2), .V_SYNC(3), .V_BP(3),
      .SYNC_POL(1'b1)
   ) dut_s (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .hc(hc1), .vc(vc1), .hsync(hs1), .vsync(vs1), .visible(vis1),
      .line_start(ls1), .frame_start(fs1)
   );

   int checks = 0;
   int errors = 0;

   // Model state: pos = pixel index within the frame, -1 = parked by reset.
   int pos   [2];
   bit ls_m  [2];
   bit fs_m  [2];
   bit hs_d  [2];
   bit vs_d  [2];
   bit vis_d [2];

   function automatic int ht(int c); return HV[c] + HF[c] + HS[c] + HB[c]; endfunction
   function automatic int vt(int c); return VV[c] + VF[c] + VS[c] + VB[c]; endfunction
   function automatic int m_hc(int c, int p); return (p < 0) ? ht(c) - 1 : p % ht(c); endfunction
   function automatic int m_vc(int c, int p); return (p < 0) ? vt(c) - 1 : p / ht(c); endfunction

   function automatic bit m_hs(int c, int p);
      int h = m_hc(c, p);
      return (h >= HV[c] + HF[c] && h < HV[c] + HF[c] + HS[c]) ? POL[c] : !POL[c];
   endfunction

   function automatic bit m_vs(int c, int p);
      int v = m_vc(c, p);
      return (v >= VV[c] + VF[c] && v < VV[c] + VF[c] + VS[c]) ? POL[c] : !POL[c];
   endfunction

   function automatic bit m_vis(int c, int p);
      return (m_hc(c, p) < HV[c]) && (m_vc(c, p) < VV[c]);
   endfunction

   task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cfg%0d observed=%0d expected=%0d", tag, c, obs, exp);
      end
   endtask

   task automatic model_update(input bit r, input bit e);
      for (int c = 0; c < 2; c++) begin
         if (r) begin
            pos[c]   = -1;
            ls_m[c]  = 1'b0;
            fs_m[c]  = 1'b0;
            hs_d[c]  = !POL[c];
            vs_d[c]  = !POL[c];
            vis_d[c] = 1'b0;
         end else if (e) begin
            hs_d[c]  = m_hs(c, pos[c]);
            vs_d[c]  = m_vs(c, pos[c]);
            vis_d[c] = m_vis(c, pos[c]);
            pos[c]   = (pos[c] + 1) % (ht(c) * vt(c));
            ls_m[c]  = (m_hc(c, pos[c]) == 0);
            fs_m[c]  = (pos[c] == 0);
         end else begin
            ls_m[c] = 1'b0;
            fs_m[c] = 1'b0;
         end
      end
   endtask

   task automatic cmp_cfg(input int c, input logic [10:0] h, input logic [10:0] v,
                          input logic hs, input logic vs, input logic vis,
                          input logic ls, input logic fs);
      chk("hc", c, h, m_hc(c, pos[c]));
      chk("vc", c, v, m_vc(c, pos[c]));
      chk("hsync", c, hs, DLY ? hs_d[c] : m_hs(c, pos[c]));
      chk("vsync", c, vs, DLY ? vs_d[c] : m_vs(c, pos[c]));
      chk("visible", c, vis, DLY ? vis_d[c] : m_vis(c, pos[c]));
      chk("line_start", c, ls, ls_m[c]);
      chk("frame_start", c, fs, fs_m[c]);
   endtask

   task automatic step(input bit r, input bit e);
      rst    = r;
      pix_en = e;
      @(posedge clk);
      model_update(r, e);
      #1;
      cmp_cfg(0, hc0, vc0, hs0, vs0, vis0, ls0, fs0);
      cmp_cfg(1, hc1, vc1, hs1, vs1, vis1, ls1, fs1);
   endtask

   // Advance the default instance with pix_en high until hc reaches target;
   // the loop is bounded and a miss shows up as a failed hc comparison.
   task automatic run_to_hc(input int target, input int budget);
      int n = 0;
      while (m_hc(0, pos[0]) != target && n < budget) begin
         step(1'b0, 1'b1);
         n++;
      end
      chk("reach_hc", 0, hc0, target);
   endtask

   initial begin
      rst    = 1'b1;
      pix_en = 1'b1;
      for (int c = 0; c < 2; c++) pos[c] = -1;

      // Reset, with pix_en high and low: reset wins.
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      chk("rst_hc", 0, hc0, 1343);
      chk("rst_vc", 0, vc0, 805);
      chk("rst_hsync", 0, hs0, 1);
      chk("rst_vsync", 1, vs1, 0);
      chk("rst_visible", 0, vis0, 0);

      // Release: first enable lands on (0,0) with both pulses.
      step(1'b0, 1'b1);
      chk("first_hc", 0, hc0, 0);
      chk("first_vc", 0, vc0, 0);
      chk("first_fs", 0, fs0, 1);
      chk("first_ls", 0, ls0, 1);
      chk("first_visible", 0, vis0, DLY ? 0 : 1);
      step(1'b0, 1'b1);
      chk("second_hc", 0, hc0, 1);
      chk("second_ls", 0, ls0, 0);
      chk("second_fs", 0, fs0, 0);

      // Horizontal sync edges and end of visible region.
      run_to_hc(1023, 2000);
      step(1'b0, 1'b1);
      chk("vis_end", 0, vis0, DLY ? 1 : 0);
      run_to_hc(1047, 2000);
      step(1'b0, 1'b1);
      chk("hs_fall_1048", 0, hs0, DLY ? 1 : 0);
      step(1'b0, 1'b1);
      chk("hs_low_1049", 0, hs0, 0);
      run_to_hc(1183, 2000);
      step(1'b0, 1'b1);
      chk("hs_rise_1184", 0, hs0, DLY ? 0 : 1);

      // Line wrap, then pix_en 1,0,0,1 with a stall at hc = 0.
      run_to_hc(1343, 2000);
      step(1'b0, 1'b1);
      chk("wrap_vc", 0, vc0, 1);
      chk("wrap_ls", 0, ls0, 1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("stall_hc", 0, hc0, 0);
      chk("stall_ls", 0, ls0, 0);
      step(1'b0, 1'b1);
      chk("resume_hc", 0, hc0, 1);

      // Randomly gated pixel strobe.
      repeat (8000) step(1'b0, $urandom_range(0, 3) != 0);

      // Mid-line reset, then a clean restart.
      run_to_hc(500, 2000);
      step(1'b1, 1'b1);
      chk("midrst_hc", 0, hc0, 1343);
      chk("midrst_ls", 0, ls0, 0);
      chk("midrst_fs", 0, fs0, 0);
      step(1'b0, 1'b1);
      chk("restart_fs", 0, fs0, 1);

      // Free running: many small frames, several default lines.
      repeat (3000) step(1'b0, 1'b1);

      // Random strobe with occasional resets.
      repeat (15000) step($urandom_range(0, 999) == 0, $urandom_range(0, 1) == 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
